// File: rtl/sobel_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sobel_window_sequencer
// Brief   : Builds 3x3 windows from a raster stream and packs the operands.
//           Sequences the shared start/done handshake of two Sobel cores and
//           emits their averaged result and the frame maximum.
// Revision: 1.0  initial release
// ============================================================================
module sobel_window_sequencer #(
  parameter int COLS = 50,
  parameter int ROWS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        core_start,
  input  logic        core_done,
  output logic [47:0] x_ops,
  output logic [47:0] y_ops,
  input  logic [7:0]  x_res,
  input  logic [7:0]  y_res,
  output logic [7:0]  edge_out,
  output logic        edge_valid,
  output logic [7:0]  edge_max,
  output logic        frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic        done_q, done_d;
  logic        last_q, last_d;
  logic [47:0] x_ops_q, x_ops_d, y_ops_q, y_ops_d;
  logic [7:0]  edge_out_q, edge_out_d, edge_max_q, edge_max_d;
  // Window history: *1 holds column col-1, *2 holds column col-2.
  logic [7:0]  t1_q, t1_d, t2_q, t2_d;
  logic [7:0]  m1_q, m1_d, m2_q, m2_d;
  logic [7:0]  b1_q, b1_d, b2_q, b2_d;

  logic [7:0]  lb1_mem [COLS];  // row-1
  logic [7:0]  lb2_mem [COLS];  // row-2

  logic        accept;
  logic [7:0]  up_pix, mid_pix, edge_new;

  assign accept   = pix_valid && (state_q == S_FILL);
  assign up_pix   = lb2_mem[col_q];
  assign mid_pix  = lb1_mem[col_q];
  assign edge_new = 8'(({1'b0, x_res} + {1'b0, y_res}) >> 1);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    done_d     = core_done;
    last_d     = last_q;
    x_ops_d    = x_ops_q;
    y_ops_d    = y_ops_q;
    edge_out_d = edge_out_q;
    edge_max_d = edge_max_q;
    t1_d = t1_q; t2_d = t2_q;
    m1_d = m1_q; m2_d = m2_q;
    b1_d = b1_q; b2_d = b2_q;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          t2_d = t1_q; t1_d = up_pix;
          m2_d = m1_q; m1_d = mid_pix;
          b2_d = b1_q; b1_d = pix_in;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (row_q == '0 && col_q == '0)
            edge_max_d = 8'd0;
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            x_ops_d = {b2_q, m2_q, t2_q, pix_in, mid_pix, up_pix};
            y_ops_d = {pix_in, b1_q, b2_q, up_pix, t1_q, t2_q};
            last_d  = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // done_q tracks core_done in every state, so a level left high from
        // the previous window never looks like a fresh rising edge here.
        if (core_done && !done_q) begin
          edge_out_d = edge_new;
          if (edge_new > edge_max_q)
            edge_max_d = edge_new;
          state_d = S_EMIT;
        end
      end
      S_EMIT:  state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FILL;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      x_ops_q    <= '0;
      y_ops_q    <= '0;
      edge_out_q <= '0;
      edge_max_q <= '0;
      t1_q <= '0; t2_q <= '0;
      m1_q <= '0; m2_q <= '0;
      b1_q <= '0; b2_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
      last_q     <= last_d;
      x_ops_q    <= x_ops_d;
      y_ops_q    <= y_ops_d;
      edge_out_q <= edge_out_d;
      edge_max_q <= edge_max_d;
      t1_q <= t1_d; t2_q <= t2_d;
      m1_q <= m1_d; m2_q <= m2_d;
      b1_q <= b1_d; b2_q <= b2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_mem[col_q] <= mid_pix;
      lb1_mem[col_q] <= pix_in;
    end
  end

  assign pix_ready  = (state_q == S_FILL);
  assign core_start = (state_q != S_RUN);
  assign edge_valid = (state_q == S_EMIT);
  assign frame_done = (state_q == S_EMIT) && last_q;
  assign x_ops      = x_ops_q;
  assign y_ops      = y_ops_q;
  assign edge_out   = edge_out_q;
  assign edge_max   = edge_max_q;

endmodule
`default_nettype wire
